// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: width default, clog2
// sizing helper and the stream beat record.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    int unsigned span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

  typedef struct packed {
    logic [FIFO_WIDTH_DEFAULT-1:0] data;
    logic                          last;
  } stream_beat_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Circular prefetch buffer with wrapping pointers, occupancy count and
// registered storage feeding the stream output directly.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    valid,
  output logic [clog2(DEPTH):0]   occ
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      occ_q;

  // Storage is cleared on reset so the output word reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + (PW + 1)'(1);
        2'b01:   occ_q <= occ_q - (PW + 1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign valid   = (occ_q != '0);
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: credit-limited rd_en issue into a prefetch buffer,
// ready/valid stream out. Define FIFO_STREAM_READER_LAST_EN for burst m_last.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]       fifo_dout,
  input  logic                        fifo_valid,
  input  logic                        fifo_empty,
  output logic [FIFO_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
`ifdef FIFO_STREAM_READER_LAST_EN
  output logic                        m_last,
`endif
  output logic [clog2(BUF_DEPTH):0]   buf_count,
  output logic                        proto_err
);

  localparam int unsigned CW = clog2(BUF_DEPTH) + 1;

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || BURST_LEN < 1) begin : g_param_check
    $error("fifo_stream_reader: BUF_DEPTH must be a power of two >= 2 and BURST_LEN >= 1");
  end

  logic          inflight;
  logic          first_cycle;
  logic          pop;
  logic          wr_en;
  logic [CW:0]   credit_used;
  logic [CW:0]   credit_cap;

  assign pop   = m_valid && m_ready;
  assign wr_en = fifo_valid && inflight;

  // occ + inflight - pop < BUF_DEPTH, with pop moved to the right-hand side
  assign credit_used = {1'b0, buf_count} + {{CW{1'b0}}, inflight};
  assign credit_cap  = (CW + 1)'(BUF_DEPTH) + {{CW{1'b0}}, pop};

  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && !fifo_empty && (credit_used < credit_cap)) begin
      fifo_rd_en = 1'b1;
    end
  end

  // first_cycle marks the cycle after reset, where stray returns are ignored silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      first_cycle <= 1'b1;
      proto_err   <= 1'b0;
    end else begin
      inflight    <= fifo_rd_en;
      first_cycle <= 1'b0;
      if (fifo_valid && !inflight && !first_cycle) begin
        proto_err <= 1'b1;
      end
    end
  end

  stream_skid_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (fifo_dout),
    .rd_en   (pop),
    .rd_data (m_data),
    .valid   (m_valid),
    .occ     (buf_count)
  );

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int unsigned BW = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;

  logic [BW-1:0] beat_cnt;
  logic          beat_wrap;

  assign beat_wrap = (beat_cnt == BW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_wrap ? '0 : beat_cnt + BW'(1);
    end
  end

  assign m_last = m_valid && beat_wrap;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model, occupancy/credit
// reference model, in-order scoreboard, vector table and corner sequences.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int BURST = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_valid = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [1:0]   buf_count;
  logic         proto_err;
`ifdef FIFO_STREAM_READER_LAST_EN
  logic         m_last;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .FIFO_WIDTH (W),
    .BUF_DEPTH  (DEPTH),
    .BURST_LEN  (BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef FIFO_STREAM_READER_LAST_EN
    .m_last     (m_last),
`endif
    .buf_count  (buf_count),
    .proto_err  (proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO contents and expected output order
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];

  // Reference state: words held = legit returns - accepted beats
  int           mocc  = 0;
  int           mbeat = 0;
  int           n_rx  = 0;
  int           last_mask = 0;
  logic         minfl  = 1'b0;
  logic         mproto = 1'b0;
  logic         mfirst = 1'b1;
  logic         pend_v = 1'b0;
  logic [W-1:0] pend_d = '0;
  logic         inj    = 1'b0;
  logic [W-1:0] inj_d  = '0;
  logic         hold   = 1'b0;
  logic [W-1:0] hold_d = '0;

  logic         s_rd, s_mv, s_pop, s_pe, s_last;
  logic [W-1:0] s_md;
  logic [1:0]   s_bc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    int exp_rd;
    fifo_valid = pend_v || inj;
    fifo_dout  = pend_v ? pend_d : inj_d;
    fifo_empty = (fq.size() == 0);
    #1;
    s_rd  = fifo_rd_en;
    s_mv  = m_valid;
    s_md  = m_data;
    s_bc  = buf_count;
    s_pe  = proto_err;
    s_pop = m_valid && m_ready;
`ifdef FIFO_STREAM_READER_LAST_EN
    s_last = m_last;
    check("m_last", s_last, (s_mv && mbeat == BURST - 1));
`else
    s_last = 1'b0;
`endif
    exp_rd = (!rst && !fifo_empty &&
              (mocc + int'(minfl) - int'(s_pop)) < DEPTH) ? 1 : 0;
    check("rd_en", s_rd, exp_rd);
    check("m_valid", s_mv, (mocc != 0));
    check("buf_count", s_bc, mocc);
    check("proto_err", s_pe, mproto);
    if (hold) begin
      check("hold_valid", s_mv, 1);
      check("hold_data", s_md, hold_d);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mocc   = 0;
      mbeat  = 0;
      minfl  = 1'b0;
      mproto = 1'b0;
      mfirst = 1'b1;
      pend_v = 1'b0;
      hold   = 1'b0;
      exp_q.delete();
    end else begin
      if (fifo_valid && !minfl && !mfirst) mproto = 1'b1;
      if (fifo_valid && minfl) mocc++;
      if (s_pop) begin
        check("beat_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("beat_data", s_md, exp_q.pop_front());
        mocc--;
        n_rx++;
        if (s_last) last_mask |= (1 << n_rx);
        mbeat = (mbeat + 1) % BURST;
      end
      hold   = s_mv && !s_pop;
      hold_d = s_md;
      minfl  = s_rd;
      mfirst = 1'b0;
      pend_v = s_rd;
      if (s_rd) begin
        check("rd_fifo_nonempty", (fq.size() != 0), 1);
        if (fq.size() != 0) begin
          pend_d = fq.pop_front();
          exp_q.push_back(pend_d);
        end
      end
    end
    inj = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inj = 1'b0;
    fq.delete();
    repeat (3) step();
    check("rst_m_data", s_md, 0);
    check("rst_m_valid", s_mv, 0);
    check("rst_buf_count", s_bc, 0);
    check("rst_proto_err", s_pe, 0);
    check("rst_rd_en", s_rd, 0);
    rst = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    while (n_rx < target && budget > 0) begin
      step();
      budget--;
    end
    check(name, n_rx, target);
  endtask

  typedef struct {
    logic         rd;
    logic         mv;
    logic [W-1:0] md;
    logic         chk_md;
    logic [1:0]   bc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int pulses, max_bc, pushed, viol, budget;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b1, 2'd1};
    tbl[3] = '{1'b0, 1'b1, 8'h22, 1'b1, 2'd1};
    tbl[4] = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0};

    repeat (2) @(posedge clk);
    #1;

    // Latency and back-to-back throughput
    do_reset();
    n_rx = 0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("tbl%0d_rd_en", i), s_rd, tbl[i].rd);
      check($sformatf("tbl%0d_m_valid", i), s_mv, tbl[i].mv);
      check($sformatf("tbl%0d_buf_count", i), s_bc, tbl[i].bc);
      if (tbl[i].chk_md) check($sformatf("tbl%0d_m_data", i), s_md, tbl[i].md);
    end
    check("tbl_rx_count", n_rx, 3);

    // Stall: credits stop issue at BUF_DEPTH words
    do_reset();
    n_rx = 0;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'hA0 + i));
    m_ready = 1'b0;
    pulses = 0;
    max_bc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_rd) pulses++;
      if (int'(s_bc) > max_bc) max_bc = int'(s_bc);
    end
    check("stall_rd_pulses", pulses, DEPTH);
    check("stall_buf_sat", max_bc, DEPTH);
    m_ready = 1'b1;
    run_until(8, 60, "stall_drain_count");

    // Random back-pressure, 200 words through a 32-deep FIFO
    do_reset();
    n_rx = 0;
    pushed = 0;
    max_bc = 0;
    budget = 4000;
    while (n_rx < 200 && budget > 0) begin
      if (pushed < 200 && fq.size() < 32 && $urandom_range(0, 3) != 0) begin
        fq.push_back(8'($urandom));
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      step();
      if (int'(s_bc) > max_bc) max_bc = int'(s_bc);
      budget--;
    end
    check("rand_rx_count", n_rx, 200);
    check("rand_buf_max_le_depth", (max_bc <= DEPTH), 1);
    check("rand_proto_err", s_pe, 0);

    // FIFO empties with words still buffered
    do_reset();
    n_rx = 0;
    fq.push_back(8'h5A); fq.push_back(8'hC3); fq.push_back(8'h7E);
    m_ready = 1'b0;
    repeat (4) step();
    check("empty_buffered", s_bc, DEPTH);
    m_ready = 1'b1;
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fifo_empty && s_rd) viol++;
    end
    check("empty_rd_violations", viol, 0);
    check("empty_rx_count", n_rx, 3);
    check("empty_m_valid_low", s_mv, 0);
    check("empty_buf_zero", s_bc, 0);

    // Spurious fifo_valid with nothing in flight
    do_reset();
    n_rx = 0;
    m_ready = 1'b1;
    step();
    inj = 1'b1;
    inj_d = 8'hEE;
    step();
    step();
    step();
    check("spur_proto_set", s_pe, 1);
    check("spur_buf_zero", s_bc, 0);
    check("spur_m_valid", s_mv, 0);
    fq.push_back(8'h01); fq.push_back(8'h02);
    repeat (8) step();
    check("spur_rx_after", n_rx, 2);
    check("spur_proto_sticky", s_pe, 1);
    do_reset();
    inj = 1'b1;
    inj_d = 8'hDD;
    repeat (3) step();
    check("postrst_proto_clear", s_pe, 0);
    check("postrst_buf_zero", s_bc, 0);
    check("postrst_m_valid", s_mv, 0);

`ifdef FIFO_STREAM_READER_LAST_EN
    // Burst markers on beats 4 and 8; reset restarts the count
    do_reset();
    n_rx = 0;
    last_mask = 0;
    for (int i = 0; i < 9; i++) fq.push_back(8'(8'h40 + i));
    m_ready = 1'b1;
    run_until(9, 60, "last_rx_count");
    check("last_beats_4_8", last_mask, (1 << 4) | (1 << 8));
    do_reset();
    n_rx = 0;
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h60 + i));
    run_until(2, 40, "last_pre_rst_count");
    do_reset();
    n_rx = 0;
    last_mask = 0;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h70 + i));
    run_until(4, 40, "last_post_rst_count");
    check("last_after_rst_beat4", last_mask, (1 << 4));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
